reg_mux_nx1: RTL

//  Parametrised N:1 datapath select with a registered output and a valid/ready handshake.

---
 rtl/reg_mux_nx1_pkg.sv | 14 +
 rtl/mux_nx1_comb.sv | 27 ++
 rtl/reg_mux_nx1.sv | 114 +++++++++++
 3 files changed

// File: rtl/reg_mux_nx1_pkg.sv
// Shared definitions for the registered N:1 select: handshake state encoding and
// the supported range of NUM_IN.
package reg_mux_nx1_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL1 = 2'b01,
      ST_FULL2 = 2'b10
   } state_e;

   localparam int MIN_NUM_IN = 2;
   localparam int MAX_NUM_IN = 16;

endpackage

// File: rtl/mux_nx1_comb.sv
// Purely combinational indexed N:1 select. An out-of-range select yields zero data
// and raises sel_err, so no X can leak into the datapath.
module mux_nx1_comb #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]        data_out,
   output logic                    sel_err
);

   logic hit_s;

   // AND-OR select; a select that matches no input leaves the result at zero
   always_comb begin
      data_out = '0;
      hit_s    = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         data_out = data_out | ({WIDTH{sel == SEL_W'(i)}} & data_in[i*WIDTH +: WIDTH]);
         hit_s    = hit_s | (sel == SEL_W'(i));
      end
      sel_err = ~hit_s;
   end

endmodule

// File: rtl/reg_mux_nx1.sv
// N:1 datapath select with a registered output and a one-entry skid buffer, giving
// full throughput under back-pressure with in_ready driven straight from a flop.
module reg_mux_nx1
   import reg_mux_nx1_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        data_out,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err
);

   state_e             state_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [WIDTH-1:0]   data_r;
   logic [SEL_W-1:0]   sel_r;
   logic               err_r;
   logic [WIDTH-1:0]   skid_data_r;
   logic [SEL_W-1:0]   skid_sel_r;
   logic               skid_err_r;
   logic [WIDTH-1:0]   mux_data_s;
   logic               mux_err_s;
   logic               accept_s;
   logic               take_s;

   mux_nx1_comb #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_sel (
      .sel      (sel),
      .data_in  (data_in),
      .data_out (mux_data_s),
      .sel_err  (mux_err_s)
   );

   assign accept_s  = in_valid & in_ready_r;
   assign take_s    = out_valid_r & out_ready;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign data_out  = data_r;
   assign out_sel   = sel_r;
   assign sel_err   = err_r;

   // Handshake state, output register and skid register; the select is captured at acceptance
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         data_r      <= '0;
         sel_r       <= '0;
         err_r       <= 1'b0;
         skid_data_r <= '0;
         skid_sel_r  <= '0;
         skid_err_r  <= 1'b0;
      end else begin
         in_ready_r <= 1'b1;
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  data_r      <= mux_data_s;
                  sel_r       <= sel;
                  err_r       <= mux_err_s;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_FULL1;
               end
            end
            ST_FULL1: begin
               if (accept_s && take_s) begin
                  data_r <= mux_data_s;
                  sel_r  <= sel;
                  err_r  <= mux_err_s;
               end else if (accept_s) begin
                  skid_data_r <= mux_data_s;
                  skid_sel_r  <= sel;
                  skid_err_r  <= mux_err_s;
                  in_ready_r  <= 1'b0;
                  state_r     <= ST_FULL2;
               end else if (take_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_EMPTY;
               end
            end
            ST_FULL2: begin
               // Skid beat is older than anything upstream, so it drains first
               in_ready_r <= take_s;
               if (take_s) begin
                  data_r  <= skid_data_r;
                  sel_r   <= skid_sel_r;
                  err_r   <= skid_err_r;
                  state_r <= ST_FULL1;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule
